rf_write_arbiter: RTL and testbench

Write-port controller for the 32 x 8 register file, which has one write port whose address (`ADRX`) also drives the X read port. The block does three things:
- Shares the single write port between the CPU writeback path (requester A) and the debug/loader path (requester B), using round-robin arbitration with valid/ready handshakes.
- Owns the register file's `ADRX` and `DIN` inputs, passing the CPU's X read address through whenever no write is in progress.
- Zeroes all 32 registers after reset or on request, so the register file needs no initial block.

---
 rtl/rat_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/rf_write_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared types and sizes for the register-file write-port controller.
package rat_pkg;

  localparam int unsigned RF_DATA_W   = 8;
  localparam int unsigned RF_ADDR_W   = 5;
  localparam int unsigned RF_NUM_REGS = 32;

  // CLEAR walks every address writing zero; IDLE arbitrates A/B writes.
  typedef enum logic [0:0] {
    CLEAR,
    IDLE
  } rf_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant with pointer update.
// last_b_i = 1 means B won the previous grant, so A wins a tie.
module rr_arbiter2 (
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o,
  output logic last_b_o
);

  // Grant at most one requester; the pointer only moves on a grant.
  always_comb begin
    gnt_a_o  = 1'b0;
    gnt_b_o  = 1'b0;
    last_b_o = last_b_i;
    if (en_i) begin
      if (req_a_i && (!req_b_i || last_b_i)) begin
        gnt_a_o  = 1'b1;
        last_b_o = 1'b0;
      end else if (req_b_i) begin
        gnt_b_o  = 1'b1;
        last_b_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port controller for the 32 x 8 register file: clears every register after
// reset or on request, then shares the single write port between the CPU (A) and
// the debug/loader path (B). ADRX carries the CPU X read address whenever no write
// is in progress.
module rf_write_arbiter
  import rat_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  input  logic [ADDR_W-1:0] CPU_ADRX,
  input  logic              A_WR_VALID,
  input  logic [ADDR_W-1:0] A_WR_ADR,
  input  logic [DATA_W-1:0] A_WR_DATA,
  output logic              A_WR_READY,
  input  logic              B_WR_VALID,
  input  logic [ADDR_W-1:0] B_WR_ADR,
  input  logic [DATA_W-1:0] B_WR_DATA,
  output logic              B_WR_READY,
  output logic              RF_WR,
  output logic [ADDR_W-1:0] RF_ADRX,
  output logic [DATA_W-1:0] RF_DIN
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  rf_arb_state_t     state, state_d;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_d;
  logic              last_b, last_b_d;

  logic arb_en;
  logic gnt_a, gnt_b;
  logic arb_last_b;

  // A clear request wins over both requesters in the cycle it arrives.
  assign arb_en = (state == IDLE) && !CLR_REQ;

  rr_arbiter2 u_rr_arbiter2 (
    .en_i     (arb_en),
    .req_a_i  (A_WR_VALID),
    .req_b_i  (B_WR_VALID),
    .last_b_i (last_b),
    .gnt_a_o  (gnt_a),
    .gnt_b_o  (gnt_b),
    .last_b_o (arb_last_b)
  );

  // State register; reset restarts the clear and lets A win the first tie.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      last_b  <= 1'b1;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
      last_b  <= last_b_d;
    end
  end

  // Next-state: walk the clear address, or take a clear request from IDLE.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    last_b_d  = arb_last_b;
    unique case (state)
      CLEAR: begin
        if (clr_cnt == LastAddr) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (CLR_REQ) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Outputs: combinational from state plus the current request inputs.
  always_comb begin
    CLR_BUSY   = 1'b0;
    A_WR_READY = 1'b0;
    B_WR_READY = 1'b0;
    RF_WR      = 1'b0;
    RF_ADRX    = CPU_ADRX;
    RF_DIN     = '0;
    unique case (state)
      CLEAR: begin
        CLR_BUSY = 1'b1;
        RF_WR    = 1'b1;
        RF_ADRX  = clr_cnt;
      end
      IDLE: begin
        if (gnt_a) begin
          A_WR_READY = 1'b1;
          RF_WR      = 1'b1;
          RF_ADRX    = A_WR_ADR;
          RF_DIN     = A_WR_DATA;
        end else if (gnt_b) begin
          B_WR_READY = 1'b1;
          RF_WR      = 1'b1;
          RF_ADRX    = B_WR_ADR;
          RF_DIN     = B_WR_DATA;
        end
      end
      default: begin
        CLR_BUSY = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a behavioural 32 x 8 register file sits on the RF_*
// outputs so writes can be read back, and expected transfers are queued as they
// are driven and popped as the DUT grants them.
module tb_rf_write_arbiter;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       CLR_REQ = 1'b0;
  logic       CLR_BUSY;
  logic [4:0] CPU_ADRX = '0;
  logic       A_WR_VALID = 1'b0;
  logic [4:0] A_WR_ADR = '0;
  logic [7:0] A_WR_DATA = '0;
  logic       A_WR_READY;
  logic       B_WR_VALID = 1'b0;
  logic [4:0] B_WR_ADR = '0;
  logic [7:0] B_WR_DATA = '0;
  logic       B_WR_READY;
  logic       RF_WR;
  logic [4:0] RF_ADRX;
  logic [7:0] RF_DIN;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_b;
    logic [4:0] adr;
    logic [7:0] data;
  } xfer_t;

  xfer_t exp_q[$];

  logic [7:0] rf[32];
  logic       preload = 1'b0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk        (clk),
    .RST        (RST),
    .CLR_REQ    (CLR_REQ),
    .CLR_BUSY   (CLR_BUSY),
    .CPU_ADRX   (CPU_ADRX),
    .A_WR_VALID (A_WR_VALID),
    .A_WR_ADR   (A_WR_ADR),
    .A_WR_DATA  (A_WR_DATA),
    .A_WR_READY (A_WR_READY),
    .B_WR_VALID (B_WR_VALID),
    .B_WR_ADR   (B_WR_ADR),
    .B_WR_DATA  (B_WR_DATA),
    .B_WR_READY (B_WR_READY),
    .RF_WR      (RF_WR),
    .RF_ADRX    (RF_ADRX),
    .RF_DIN     (RF_DIN)
  );

  // Register file model: same-edge write capture, optional nonzero preload.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 8'h80 | 8'(i);
    end else if (RF_WR) begin
      rf[RF_ADRX] <= RF_DIN;
    end
  end

  task automatic test_reset();
    // Preload, then hold reset across another edge.
    preload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    #1;
    checks++;
    if (CLR_BUSY !== 1'b1 || RF_ADRX !== 5'd0 || RF_WR !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: busy=%b adrx=%0d wr=%b required busy=1 adrx=0 wr=1",
               CLR_BUSY, RF_ADRX, RF_WR);
    end
    @(negedge clk);
    RST = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (CLR_BUSY !== 1'b1 || RF_WR !== 1'b1 || RF_ADRX !== 5'(k) || RF_DIN !== 8'h00 ||
          A_WR_READY !== 1'b0 || B_WR_READY !== 1'b0) begin
        errors++;
        $display("FAIL reset_clear[%0d]: busy=%b wr=%b adrx=%0d din=%h required 1 1 %0d 00",
                 k, CLR_BUSY, RF_WR, RF_ADRX, RF_DIN, k);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (CLR_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: busy=%b required 0", CLR_BUSY);
    end
    for (int a = 0; a < 32; a++) begin
      checks++;
      if (rf[a] !== 8'h00) begin
        errors++;
        $display("FAIL reset_readback[%0d]: got %h required 00", a, rf[a]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    xfer_t e;
    A_WR_VALID = 1'b1; A_WR_ADR = 5'd3; A_WR_DATA = 8'h11;
    B_WR_VALID = 1'b1; B_WR_ADR = 5'd3; B_WR_DATA = 8'h22;
    exp_q.push_back('{is_b: 1'b0, adr: 5'd3, data: 8'h11});
    exp_q.push_back('{is_b: 1'b1, adr: 5'd3, data: 8'h22});
    exp_q.push_back('{is_b: 1'b0, adr: 5'd3, data: 8'h11});
    exp_q.push_back('{is_b: 1'b1, adr: 5'd3, data: 8'h22});
    for (int c = 0; c < 4; c++) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if (A_WR_READY !== !e.is_b || B_WR_READY !== e.is_b || RF_WR !== 1'b1 ||
          RF_ADRX !== e.adr || RF_DIN !== e.data) begin
        errors++;
        $display("FAIL contention[%0d]: rdyA=%b rdyB=%b wr=%b adrx=%0d din=%h required %b %b 1 %0d %h",
                 c, A_WR_READY, B_WR_READY, RF_WR, RF_ADRX, RF_DIN, !e.is_b, e.is_b,
                 e.adr, e.data);
      end
      @(negedge clk);
    end
    A_WR_VALID = 1'b0;
    B_WR_VALID = 1'b0;
    #1;
    checks++;
    if (rf[3] !== 8'h22) begin
      errors++;
      $display("FAIL contention_final: reg3=%h required 22", rf[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    xfer_t e;
    A_WR_VALID = 1'b1; A_WR_ADR = 5'd5; A_WR_DATA = 8'hA5;
    exp_q.push_back('{is_b: 1'b0, adr: 5'd5, data: 8'hA5});
    #1;
    checks++;
    if (A_WR_READY !== 1'b1 || B_WR_READY !== 1'b0 || RF_WR !== 1'b1 || RF_ADRX !== 5'd5 ||
        RF_DIN !== 8'hA5) begin
      errors++;
      $display("FAIL single_grant: rdyA=%b rdyB=%b wr=%b adrx=%0d din=%h required 1 0 1 5 a5",
               A_WR_READY, B_WR_READY, RF_WR, RF_ADRX, RF_DIN);
    end
    @(negedge clk);
    A_WR_VALID = 1'b0;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rf[e.adr] !== e.data || A_WR_READY !== 1'b0) begin
      errors++;
      $display("FAIL single_readback: reg%0d=%h rdyA=%b required %h 0",
               e.adr, rf[e.adr], A_WR_READY, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    logic [4:0] adrs[2];
    adrs[0] = 5'd7;
    adrs[1] = 5'd19;
    for (int i = 0; i < 2; i++) begin
      CPU_ADRX = adrs[i];
      #1;
      checks++;
      if (RF_ADRX !== adrs[i] || RF_WR !== 1'b0 || A_WR_READY !== 1'b0 ||
          B_WR_READY !== 1'b0) begin
        errors++;
        $display("FAIL passthrough[%0d]: adrx=%0d wr=%b rdyA=%b rdyB=%b required %0d 0 0 0",
                 i, RF_ADRX, RF_WR, A_WR_READY, B_WR_READY, adrs[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clr_with_b();
    xfer_t e;
    int    held_off;
    CLR_REQ = 1'b1;
    B_WR_VALID = 1'b1; B_WR_ADR = 5'd9; B_WR_DATA = 8'h3C;
    exp_q.push_back('{is_b: 1'b1, adr: 5'd9, data: 8'h3C});
    held_off = 0;
    for (int c = 0; c < 33; c++) begin
      #1;
      checks++;
      if (B_WR_READY !== 1'b0 || (c == 0 && RF_WR !== 1'b0) ||
          (c > 0 && (CLR_BUSY !== 1'b1 || RF_ADRX !== 5'(c - 1)))) begin
        errors++;
        $display("FAIL clr_b_wait[%0d]: rdyB=%b wr=%b busy=%b adrx=%0d required rdyB=0",
                 c, B_WR_READY, RF_WR, CLR_BUSY, RF_ADRX);
      end else begin
        held_off++;
      end
      @(negedge clk);
      CLR_REQ = 1'b0;
    end
    #1;
    e = exp_q.pop_front();
    checks++;
    if (B_WR_READY !== 1'b1 || CLR_BUSY !== 1'b0 || RF_ADRX !== e.adr || RF_DIN !== e.data) begin
      errors++;
      $display("FAIL clr_b_grant: rdyB=%b busy=%b adrx=%0d din=%h required 1 0 %0d %h (held %0d)",
               B_WR_READY, CLR_BUSY, RF_ADRX, RF_DIN, e.adr, e.data, held_off);
    end
    @(negedge clk);
    B_WR_VALID = 1'b0;
    #1;
    checks++;
    if (rf[9] !== 8'h3C || rf[5] !== 8'h00 || rf[3] !== 8'h00) begin
      errors++;
      $display("FAIL clr_b_readback: reg9=%h reg5=%h reg3=%h required 3c 00 00",
               rf[9], rf[5], rf[3]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_clear();
    CLR_REQ = 1'b1;
    @(negedge clk);
    CLR_REQ = 1'b0;
    for (int k = 0; k < 17; k++) @(negedge clk);
    #1;
    checks++;
    if (RF_ADRX !== 5'd17 || CLR_BUSY !== 1'b1) begin
      errors++;
      $display("FAIL midclr_at17: adrx=%0d busy=%b required 17 1", RF_ADRX, CLR_BUSY);
    end
    RST = 1'b1;
    A_WR_VALID = 1'b1; A_WR_ADR = 5'd12; A_WR_DATA = 8'hEE;
    @(negedge clk);
    RST = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      checks++;
      if (CLR_BUSY !== 1'b1 || RF_ADRX !== 5'(k) || RF_DIN !== 8'h00 || A_WR_READY !== 1'b0) begin
        errors++;
        $display("FAIL midclr_restart[%0d]: busy=%b adrx=%0d din=%h rdyA=%b required 1 %0d 00 0",
                 k, CLR_BUSY, RF_ADRX, RF_DIN, A_WR_READY, k);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (CLR_BUSY !== 1'b0 || A_WR_READY !== 1'b1 || RF_ADRX !== 5'd12) begin
      errors++;
      $display("FAIL midclr_done: busy=%b rdyA=%b adrx=%0d required 0 1 12",
               CLR_BUSY, A_WR_READY, RF_ADRX);
    end
    @(negedge clk);
    A_WR_VALID = 1'b0;
    #1;
    checks++;
    if (rf[12] !== 8'hEE || rf[9] !== 8'h00) begin
      errors++;
      $display("FAIL midclr_readback: reg12=%h reg9=%h required ee 00", rf[12], rf[9]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_passthrough();
    test_clr_with_b();
    test_reset_mid_clear();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
